// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register-file access sequencer.
package reg_access_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic RF_READ  = 1'b1;
  localparam logic RF_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR_ISSUE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small synchronous FIFO of {addr, data} write requests with count/full/empty flags.
module reg_wr_fifo
  import reg_access_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= '0;
        data_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        addr_mem_r[wr_ptr_r] <= push_addr;
        data_mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// Owns the register file's shared rw/addr/data ports: drains queued writes ahead of
// later reads and sequences the register file's registered-read timing.
module reg_access_sequencer
  import reg_access_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int WQ_DEPTH       = 2,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rf_rw,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [DATA_W-1:0] rf_data_in1,
  output logic [DATA_W-1:0] rf_data_in2,
  input  logic [DATA_W-1:0] rf_data_out1,
  input  logic [DATA_W-1:0] rf_data_out2
);

  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;

  seq_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s, empty_s;
  logic              push_s, pop_s, wr_zero_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  logic              rf_rw_r, rf_rw_nxt_s;
  logic [ADDR_W-1:0] rf_addr1_r, rf_addr1_nxt_s, rf_addr2_r, rf_addr2_nxt_s;
  logic [DATA_W-1:0] rf_data_in1_r, rf_data_in1_nxt_s, rf_data_in2_r, rf_data_in2_nxt_s;
  logic              rd_valid_r, rd_valid_nxt_s;
  logic [DATA_W-1:0] rd_data1_r, rd_data1_nxt_s, rd_data2_r, rd_data2_nxt_s;

  function automatic logic [DATA_W-1:0] zero_fix(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] res;
    if (ZERO_HARDWIRED && (addr == '0)) res = '0;
    else                                res = data;
    return res;
  endfunction

  // Writes to the hardwired zero register are acknowledged but never reach the queue.
  assign wr_zero_s = ZERO_HARDWIRED && (wr_addr == '0);
  assign wr_ready  = !full_s;
  assign push_s    = wr_req && !full_s && !wr_zero_s;
  assign rd_ready  = (state_r == IDLE) && (count_s == '0) && !wr_req;

  reg_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wr_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Next state, next register-file port values and read capture.
  always_comb begin
    state_nxt_s       = state_r;
    pop_s             = 1'b0;
    rf_rw_nxt_s       = RF_READ;
    rf_addr1_nxt_s    = rf_addr1_r;
    rf_addr2_nxt_s    = rf_addr2_r;
    rf_data_in1_nxt_s = rf_data_in1_r;
    rf_data_in2_nxt_s = rf_data_in2_r;
    rd_valid_nxt_s    = 1'b0;
    rd_data1_nxt_s    = rd_data1_r;
    rd_data2_nxt_s    = rd_data2_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_nxt_s = WR_ISSUE;
        end else if (rd_req && rd_ready) begin
          state_nxt_s    = RD_ISSUE;
          rf_addr1_nxt_s = rd_addr1;
          rf_addr2_nxt_s = rd_addr2;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_ISSUE: begin
        if (!empty_s) state_nxt_s = WR_ISSUE;
        else          state_nxt_s = IDLE;
      end
      RD_ISSUE: state_nxt_s = RD_WAIT;
      RD_WAIT: begin
        state_nxt_s    = IDLE;
        rd_valid_nxt_s = 1'b1;
        rd_data1_nxt_s = zero_fix(rf_addr1_r, rf_data_out1);
        rd_data2_nxt_s = zero_fix(rf_addr2_r, rf_data_out2);
      end
      default: state_nxt_s = IDLE;
    endcase
    // The queue head is popped on entry to each WR_ISSUE cycle and presented on both ports.
    if (state_nxt_s == WR_ISSUE) begin
      pop_s             = 1'b1;
      rf_rw_nxt_s       = RF_WRITE;
      rf_addr1_nxt_s    = head_addr_s;
      rf_addr2_nxt_s    = head_addr_s;
      rf_data_in1_nxt_s = head_data_s;
      rf_data_in2_nxt_s = head_data_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      rf_rw_r       <= RF_READ;
      rf_addr1_r    <= '0;
      rf_addr2_r    <= '0;
      rf_data_in1_r <= '0;
      rf_data_in2_r <= '0;
      rd_valid_r    <= 1'b0;
      rd_data1_r    <= '0;
      rd_data2_r    <= '0;
    end else begin
      state_r       <= state_nxt_s;
      rf_rw_r       <= rf_rw_nxt_s;
      rf_addr1_r    <= rf_addr1_nxt_s;
      rf_addr2_r    <= rf_addr2_nxt_s;
      rf_data_in1_r <= rf_data_in1_nxt_s;
      rf_data_in2_r <= rf_data_in2_nxt_s;
      rd_valid_r    <= rd_valid_nxt_s;
      rd_data1_r    <= rd_data1_nxt_s;
      rd_data2_r    <= rd_data2_nxt_s;
    end
  end

  assign rf_rw       = rf_rw_r;
  assign rf_addr1    = rf_addr1_r;
  assign rf_addr2    = rf_addr2_r;
  assign rf_data_in1 = rf_data_in1_r;
  assign rf_data_in2 = rf_data_in2_r;
  assign rd_valid    = rd_valid_r;
  assign rd_data1    = rd_data1_r;
  assign rd_data2    = rd_data2_r;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench: register-file model, vector table, directed corner cases and
// randomized traffic scored against an architectural register-contents model.
module tb_reg_access_sequencer;

  logic        clock, reset_n;
  logic        rd_req, rd_ready, rd_valid;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        wr_req, wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rf_rw;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data_in1, rf_data_in2, rf_data_out1, rf_data_out2;

  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] rf_mem    [32];
  logic [31:0] model_mem [32];

  int checks = 0;
  int failures = 0;
  int wr_issue_cnt = 0;
  int cyc = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } wexp_t;
  typedef struct { logic [31:0] d1; logic [31:0] d2; int c; } rexp_t;
  wexp_t wq_exp[$];
  rexp_t rq_exp[$];

  typedef struct {
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
    logic [31:0] ewr;
  } vec_t;
  vec_t vecs[6];

  reg_access_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rf_rw(rf_rw), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data_in1(rf_data_in1), .rf_data_in2(rf_data_in2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Register file: writes both ports on every rw=0 edge, registered read otherwise.
  always @(posedge clock) begin
    if (pl_en) begin
      rf_mem[pl_addr] <= pl_data;
    end else if (rf_rw == 1'b0) begin
      rf_mem[rf_addr1] <= rf_data_in1;
      rf_mem[rf_addr2] <= rf_data_in2;
    end else begin
      rf_data_out1 <= rf_mem[rf_addr1];
      rf_data_out2 <= rf_mem[rf_addr2];
    end
  end

  // Scoreboard: write order, read results, read latency, no writes while a read is in flight.
  always @(posedge clock) begin
    wexp_t w;
    rexp_t r;
    cyc++;
    if (pl_en) model_mem[pl_addr] = pl_data;
    if (!reset_n) begin
      wq_exp.delete();
      rq_exp.delete();
    end else begin
      if (rf_rw == 1'b0) begin
        wr_issue_cnt++;
        chk("wr_during_read", 32'(rq_exp.size()), 32'd0);
        if (wq_exp.size() == 0) begin
          chk("spurious_wr_cycle", 32'(wq_exp.size()), 32'd1);
        end else begin
          w = wq_exp.pop_front();
          chk("wr_addr1", 32'(rf_addr1), 32'(w.a));
          chk("wr_addr2", 32'(rf_addr2), 32'(w.a));
          chk("wr_data1", rf_data_in1, w.d);
          chk("wr_data2", rf_data_in2, w.d);
        end
      end
      if (rd_valid) begin
        if (rq_exp.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rq_exp.size()), 32'd1);
        end else begin
          r = rq_exp.pop_front();
          chk("rd_latency", 32'(cyc - r.c), 32'd3);
          chk("sb_rd_data1", rd_data1, r.d1);
          chk("sb_rd_data2", rd_data2, r.d2);
        end
      end
      if (wr_req && wr_ready && (wr_addr != 5'd0)) begin
        w.a = wr_addr;
        w.d = wr_data;
        wq_exp.push_back(w);
        model_mem[wr_addr] = wr_data;
      end
      if (rd_req && rd_ready) begin
        r.d1 = (rd_addr1 == 5'd0) ? 32'd0 : model_mem[rd_addr1];
        r.d2 = (rd_addr2 == 5'd0) ? 32'd0 : model_mem[rd_addr2];
        r.c  = cyc;
        rq_exp.push_back(r);
      end
    end
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_rd_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (rd_ready) ok = 1'b1;
      @(posedge clock); #1;
    end
    chk("rd_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_rd_valid(output bit ok, output logic [31:0] d1, output logic [31:0] d2);
    ok = 1'b0; d1 = '0; d2 = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (rd_valid) begin
        ok = 1'b1; d1 = rd_data1; d2 = rd_data2;
      end
    end
    chk("rd_valid_timeout", 32'(ok), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int wr0;
    bit ok;
    logic [31:0] d1, d2;
    wr0 = wr_issue_cnt;
    rd_req = 1'b1; rd_addr1 = v.a1; rd_addr2 = v.a2;
    if (v.wr_en) begin
      wr_req = 1'b1; wr_addr = v.wa; wr_data = v.wd;
      @(negedge clock);
      chk("rd_ready_with_wr", 32'(rd_ready), 32'd0);
      chk("wr_ready_with_rd", 32'(wr_ready), 32'd1);
      @(posedge clock); #1;
      wr_req = 1'b0;
    end
    wait_rd_accept(ok);
    rd_req = 1'b0;
    wait_rd_valid(ok, d1, d2);
    if (ok) begin
      chk("vec_rd_data1", d1, v.e1);
      chk("vec_rd_data2", d2, v.e2);
    end
    chk("vec_wr_cycles", 32'(wr_issue_cnt - wr0), v.ewr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit ok;
    int wr0;
    logic [31:0] d1, d2;
    vecs[0] = '{1'b0, 5'd0,  32'd0,          5'd1,  5'd2,  32'd20,         32'd30,         32'd0};
    vecs[1] = '{1'b1, 5'd3,  32'hDEADBEEF,   5'd3,  5'd1,  32'hDEADBEEF,   32'd20,         32'd1};
    vecs[2] = '{1'b1, 5'd0,  32'd55,         5'd0,  5'd0,  32'd0,          32'd0,          32'd0};
    vecs[3] = '{1'b1, 5'd2,  32'd7,          5'd2,  5'd3,  32'd7,          32'hDEADBEEF,   32'd1};
    vecs[4] = '{1'b0, 5'd0,  32'd0,          5'd5,  5'd0,  32'hA5A50005,   32'd0,          32'd0};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF,   5'd31, 5'd30, 32'hFFFFFFFF,   32'hA5A5001E,   32'd1};

    reset_n = 1'b0; rd_req = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rf_rw", 32'(rf_rw), 32'd1);
    chk("rst_rf_addr1", 32'(rf_addr1), 32'd0);
    chk("rst_rf_addr2", 32'(rf_addr2), 32'd0);
    chk("rst_rf_data_in1", rf_data_in1, 32'd0);
    chk("rst_rf_data_in2", rf_data_in2, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data1", rd_data1, 32'd0);
    chk("rst_rd_data2", rd_data2, 32'd0);
    chk("rst_rd_ready", 32'(rd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Register 0 holds junk in the register file so hardwiring is observable.
    for (int i = 0; i < 32; i++) begin
      if (i == 1)      preload(5'(i), 32'd20);
      else if (i == 2) preload(5'(i), 32'd30);
      else             preload(5'(i), 32'hA5A50000 | 32'(i));
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while the read sits in RD_WAIT: the result must never appear.
    rd_req = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    wait_rd_accept(ok);
    rd_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_rf_rw", 32'(rf_rw), 32'd1);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_idle", 32'(rd_ready), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_rst_rd_valid_late", 32'(rd_valid), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_rst_no_valid", 32'(rd_valid), 32'd0);
    end
    @(posedge clock); #1;
    run_vec('{1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 32'd20, 32'd7, 32'd0});

    // Three writes offered back to back while a read is in flight; depth is two.
    wr0 = wr_issue_cnt;
    rd_req = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd31;
    wait_rd_accept(ok);
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = 5'd4; wr_data = 32'h44440001;
    @(negedge clock);
    chk("qf_wr_ready_0", 32'(wr_ready), 32'd1);
    @(posedge clock); #1;
    wr_addr = 5'd5; wr_data = 32'h44440002;
    @(negedge clock);
    chk("qf_wr_ready_1", 32'(wr_ready), 32'd1);
    @(posedge clock); #1;
    wr_addr = 5'd6; wr_data = 32'h44440003;
    @(negedge clock);
    chk("qf_wr_ready_full", 32'(wr_ready), 32'd0);
    chk("qf_rd_valid", 32'(rd_valid), 32'd1);
    chk("qf_rd_data1", rd_data1, 32'hDEADBEEF);
    chk("qf_rd_data2", rd_data2, 32'hFFFFFFFF);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      ok = wr_ready;
    end
    chk("qf_third_accept_timeout", 32'(ok), 32'd1);
    @(posedge clock); #1;
    wr_req = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("qf_wr_cycles", 32'(wr_issue_cnt - wr0), 32'd3);
    run_vec('{1'b0, 5'd0, 32'd0, 5'd4, 5'd6, 32'h44440001, 32'h44440003, 32'd0});

    // Randomized mixed traffic, scored entirely by the monitor.
    for (int i = 0; i < 400; i++) begin
      wr_req   = ($urandom_range(0, 9) < 3);
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_req   = 1'($urandom_range(0, 1));
      rd_addr1 = 5'($urandom_range(0, 31));
      rd_addr2 = 5'($urandom_range(0, 31));
      @(posedge clock); #1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("drain_reads", 32'(rq_exp.size()), 32'd0);
    chk("drain_writes", 32'(wq_exp.size()), 32'd0);
    run_vec('{1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
